// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the SRAM-backed memory stage.
// The state encoding is fixed at 2 bits so it can be probed on a debug bus.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          SRAM_DATA_W       = 16;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  // Byte address to 32-bit word index relative to the SRAM window (wraps mod 2^32).
  function automatic logic [31:0] word_index(input logic [31:0] address,
                                             input logic [31:0] base);
    return (address - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Cycle counter for one 16-bit SRAM phase; tc marks the last cycle of the phase
// and the count wraps to zero there so the next phase starts fresh.
module sram_phase_counter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);

  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) cnt <= '0;
    else if (tc)     cnt <= '0;
    else             cnt <= cnt + 3'd1;
  end

  assign tc = (cnt == 3'(WAIT_CYCLES));

endmodule

// File: rtl/sram_mem_controller.sv
// Memory stage: one 32-bit load/store split into two 16-bit asynchronous SRAM
// accesses; ready low freezes the pipeline while the access is in flight.
module sram_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int          ADDR_W      = 18,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n
);

  state_t            state, state_nxt;
  logic              req;
  logic              active;
  logic              tc;
  logic              op_wr;
  logic [ADDR_W-2:0] word_q;
  logic [ADDR_W-2:0] word_nxt;
  logic [31:0]       data_q;

  assign req      = rd_en | wr_en;
  assign active   = (state == LO) || (state == HI);
  // Upper word-index bits fall outside the SRAM and are dropped on purpose.
  assign word_nxt = (ADDR_W-1)'(word_index(address, BASE_ADDR));

  sram_phase_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_phase_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!active),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      word_q    <= '0;
      data_q    <= '0;
      read_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        op_wr  <= wr_en;
        word_q <= word_nxt;
        data_q <= write_data;
      end
      // Sample on the last cycle of each phase, after the SRAM access time has elapsed.
      if (!op_wr && tc && state == LO) read_data[15:0]  <= sram_dq_in;
      if (!op_wr && tc && state == HI) read_data[31:16] <= sram_dq_in;
    end
  end

  always_comb begin
    state_nxt   = state;
    ready       = 1'b0;
    sram_addr   = {word_q, (state == HI)};
    sram_dq_out = (state == HI) ? data_q[31:16] : data_q[15:0];
    sram_dq_oe  = active && op_wr;
    // Strobe released on the final cycle so the SRAM latches while addr/data hold.
    sram_we_n   = !(active && op_wr && !tc);
    case (state)
      IDLE: begin
        ready = !req;
        if (req) state_nxt = LO;
      end
      LO:   if (tc) state_nxt = HI;
      HI:   if (tc) state_nxt = DONE;
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Memory-stage block between the EXE stage register and the MEM stage register of the pipelined ARM core.
- Accepts one 32-bit load/store per request and performs it as two 16-bit accesses on an external asynchronous SRAM.
- Deasserts `ready` while busy; the core uses `~ready` as a whole-pipeline freeze.
- Replaces the single-cycle behavioural data memory.

Parameters:
- ADDR_W, 18, SRAM half-word address width.
- WAIT_CYCLES, 1, extra clock cycles held per 16-bit phase (0..7).
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- rd_en  in  1  load request (`mem_r_en` from the MEM stage).
- wr_en  in  1  store request (`mem_w_en` from the MEM stage).
- address  in  32  byte address (ALU result); word aligned, bits [1:0] ignored.
- write_data  in  32  store data (Rm value).
- read_data  out  32  load result; held until the next load completes.
- ready  out  1  access finished, or no request pending; pipeline freeze = ~ready.
- sram_addr  out  ADDR_W  SRAM half-word address.
- sram_dq_out  out  16  data driven toward SRAM.
- sram_dq_oe  out  1  tristate enable for sram_dq_out (pad is top-level).
- sram_dq_in  in  16  data from the SRAM pad.
- sram_we_n  out  1  SRAM write strobe, active-low.

Behaviour:
- Reset (rst=0 at a clk edge) applies in every state, including mid-access. The request is abandoned and the following values are loaded:
  - state=IDLE, cnt=0, read_data=0
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0
- FSM states: IDLE, LO, HI, DONE. `req` = rd_en | wr_en.
  - IDLE: if req, latch op (write if wr_en, else read; wr_en wins if both asserted), word address and write data, then go to LO with cnt=0. Otherwise stay.
  - LO: drive half-word 0; cnt increments each cycle. When cnt==WAIT_CYCLES, go to HI with cnt=0.
  - HI: same as LO for half-word 1; on completion go to DONE.
  - DONE: exactly one cycle, then IDLE unconditionally. The request is not re-sampled in DONE, even though the upstream request is still asserted in that cycle.
- Address computation: word = (address - BASE_ADDR) >> 2 (32-bit subtraction, wraps modulo 2^32).
  - LO phase: sram_addr = {word[ADDR_W-2:0], 1'b0}.
  - HI phase: sram_addr = {word[ADDR_W-2:0], 1'b1}.
  - Higher address bits are silently truncated.
- Write: during LO and HI, sram_dq_oe=1 and sram_we_n=0, except on the final cycle of each phase, where sram_we_n=1 (write-recovery edge while address and data remain stable).
  - sram_dq_out = data[15:0] in LO, data[31:16] in HI.
  - In IDLE and DONE: sram_we_n=1, sram_dq_oe=0.
- Read: sram_dq_oe=0 and sram_we_n=1 throughout.
  - On the final cycle of LO, sample sram_dq_in into read_data[15:0]; on the final cycle of HI, into read_data[31:16].
  - A write never modifies read_data.
- ready is combinational: (state==IDLE && !req) || state==DONE. It is 0 in LO and HI, and 0 in IDLE when req=1.
- Latency: request visible in IDLE at cycle t → ready=1 in cycle t+2·(WAIT_CYCLES+1)+1. With WAIT_CYCLES=1 the access takes 6 cycles total (ready high in the 6th).
- Back-to-back accesses: after DONE the pipeline advances. A new request seen in IDLE starts immediately, so there is no idle bubble beyond the IDLE sampling cycle.
- Upstream must hold rd_en, wr_en, address and write_data stable while ready=0. The block latches them anyway and ignores changes after capture.

Decomposition:
- Shared package `mem_ctrl_pkg`:
  - state enum {IDLE, LO, HI, DONE}, 2-bit encoding
  - SRAM_DATA_W=16
  - default BASE_ADDR
- One sub-module: `sram_phase_counter`, a 3-bit counter with clear and terminal-count output compared against WAIT_CYCLES.

Test Plan:
- Reset: rst=0 for 2 cycles → read_data=0, sram_we_n=1, sram_dq_oe=0, ready=1 with no request.
- Store, WAIT_CYCLES=1: wr_en=1, address=1024+8, data=0xDEADBEEF.
  - sram_addr=4 with dq_out=0xBEEF, then 5 with 0xDEAD.
  - we_n low for 1 cycle per phase; ready=1 at cycle 6.
- Load at the same address with SRAM model holding the stored halves → read_data=0xDEADBEEF when ready=1; value held through later stores.
- rd_en=wr_en=1 simultaneously → write performed; read_data unchanged.
- Reset asserted during HI of a write → next cycle state IDLE, we_n=1, oe=0; a subsequent read of the same address returns the old high half.
- WAIT_CYCLES=0, two back-to-back loads at 1024 and 1028 → each ready after 3 cycles; SRAM addresses 0, 1, 2, 3 in order.
